// File: rtl/psp_mem_pkg.sv
// Shared types and constants for the load/store memory access unit.
package psp_mem_pkg;

    localparam int unsigned MEM_SIZE_DEFAULT = 8192;

    // Access size as encoded on req_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_ILL  = 2'd3
    } size_e;

    // Access unit control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

    // True for accesses that must not reach memory: misaligned or illegal size.
    function automatic logic is_fault(input size_e size, input logic [1:0] addr_lo);
        logic f;
        case (size)
            SIZE_BYTE: f = 1'b0;
            SIZE_HALF: f = addr_lo[0];
            SIZE_WORD: f = (addr_lo != 2'b00);
            default:   f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bus between a requester and mem_access_unit.
interface mem_access_unit_if #(
    parameter int unsigned AW = 13
) ();
    logic          req_valid;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic          resp_ready;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store lane enables/data shift and load extract/extend.
module mem_lane_align
    import psp_mem_pkg::*;
(
    input  size_e       st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_lane_en,
    output logic [31:0] st_wdata_sh,
    input  size_e       ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    assign st_wdata_sh = st_wdata << {st_addr_lo, 3'b000};
    assign ld_shifted  = ld_rdata >> {ld_offset, 3'b000};

    // Store lane enables from size and byte offset.
    always_comb begin
        st_lane_en = '0;
        case (st_size)
            SIZE_BYTE: st_lane_en = 4'b0001 << st_addr_lo;
            SIZE_HALF: st_lane_en = 4'b0011 << st_addr_lo;
            SIZE_WORD: st_lane_en = 4'b1111;
            default:   st_lane_en = '0;
        endcase
    end

    // Load data: select the addressed bytes and sign- or zero-extend.
    always_comb begin
        ld_data = '0;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_HALF: ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
            SIZE_WORD: ld_data = ld_shifted;
            default:   ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: aligns byte/half/word accesses onto a 32-bit
// synchronous-read memory and returns one response per request.
module mem_access_unit
    import psp_mem_pkg::*;
#(
    parameter  int unsigned MEM_SIZE = MEM_SIZE_DEFAULT,
    localparam int unsigned AW       = $clog2(MEM_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus,
    output logic [AW-1:0]      mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_en,
    output logic               mem_we,
    input  logic [31:0]        mem_rdata
);

    state_e      state;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;
    logic [1:0]  ld_offset_q;
    size_e       ld_size_q;
    logic        ld_unsigned_q;

    size_e       req_size;
    logic        req_fault;
    logic        accept;
    logic        store_go;
    logic [3:0]  lane_en;
    logic [31:0] wdata_sh;
    logic [31:0] ld_data;

    assign req_size  = size_e'(bus.req_size);
    assign req_fault = is_fault(req_size, bus.req_addr[1:0]);
    assign accept    = bus.req_valid && (state == IDLE);
    assign store_go  = accept && bus.req_we && !req_fault;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;

    assign mem_addr  = bus.req_addr;
    assign mem_wdata = wdata_sh;
    assign mem_we    = store_go;
    assign mem_en    = store_go ? lane_en : '0;

    mem_lane_align u_align (
        .st_size     (req_size),
        .st_addr_lo  (bus.req_addr[1:0]),
        .st_wdata    (bus.req_wdata),
        .st_lane_en  (lane_en),
        .st_wdata_sh (wdata_sh),
        .ld_size     (ld_size_q),
        .ld_offset   (ld_offset_q),
        .ld_unsigned (ld_unsigned_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    // Control FSM with registered response outputs and captured load attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_fault_q  <= 1'b0;
            ld_offset_q   <= '0;
            ld_size_q     <= SIZE_BYTE;
            ld_unsigned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_fault) begin
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= RESP;
                        end else if (bus.req_we) begin
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b0;
                            resp_rdata_q <= '0;
                            state        <= RESP;
                        end else begin
                            ld_offset_q   <= bus.req_addr[1:0];
                            ld_size_q     <= req_size;
                            ld_unsigned_q <= bus.req_unsigned;
                            state         <= READ;
                        end
                    end
                end
                READ: begin
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= ld_data;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 8192, meaning the byte size of the attached memory; address width is AW = clog2(MEM_SIZE).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-004 SHALL have the following request ports, all inputs: req_valid (1), req_we (1, 1=store), req_size (2; 0=byte, 1=half, 2=word, 3=illegal), req_unsigned (1, zero-extend loads), req_addr (AW, byte address), req_wdata (32, store data, LSB-justified).
REQ-005 SHALL have port req_ready, output, 1, meaning the request is accepted when req_valid && req_ready.
REQ-006 SHALL have response ports resp_valid (output, 1), resp_rdata (output, 32, extended load data, 0 for stores and faults), resp_fault (output, 1, misaligned or illegal size), and resp_ready (input, 1).
REQ-007 SHALL have memory-side ports mem_addr (output, AW), mem_wdata (output, 32), mem_en (output, 4, byte-lane enables), mem_we (output, 1) and mem_rdata (input, 32), where mem_rdata is valid one cycle after the address is presented.

Function
REQ-008 SHALL implement the states IDLE, READ and RESP; req_ready = 1 only in IDLE.
REQ-009 SHALL perform, on acceptance of a legal store: drive mem_addr=req_addr, mem_we=1, the mem_en lanes and the shifted mem_wdata combinationally in the accept cycle, then go to RESP.
REQ-010 SHALL perform, on acceptance of a legal load: drive mem_addr=req_addr, mem_we=0, mem_en=0, register offset=req_addr[1:0], size and unsigned, then go to READ.
REQ-011 SHALL, in READ: take byte = mem_rdata >> (8*offset), sign- or zero-extend from 8/16/32 bits, register the result into resp_rdata, then go to RESP.
REQ-012 SHALL compute lane enables as: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
REQ-013 SHALL compute store data as: mem_wdata = replicated/shifted data (req_wdata << 8*addr[1:0]) truncated to 32 bits.
REQ-014 SHALL treat as a fault: half with addr[0]=1, word with addr[1:0]!=0, and size 3; on a fault it SHALL issue no memory access (mem_we=0, mem_en=0) and go directly to RESP with resp_fault=1 and resp_rdata=0.
REQ-015 SHALL hold resp_valid=1 and stable resp_rdata/resp_fault throughout RESP, and go to IDLE on the cycle resp_ready=1.
REQ-016 SHALL give the following latency from acceptance edge to resp_valid: store/fault 1 cycle, load 2 cycles.
REQ-017 SHALL drive mem_we=0 and mem_en=0 whenever no request is being accepted.
REQ-018 SHALL NOT accept a new request in the same cycle as resp_ready when resp_valid && resp_ready && req_valid coincide; the new request is accepted the following cycle in IDLE.
REQ-019 SHALL drive mem_addr=req_addr in IDLE, don't-care for the memory, for deterministic simulation.

Reset
REQ-020 SHALL, while rst_n=0: set state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0 and the registered offset/size=0; outputs SHALL be req_ready=1, mem_we=0, mem_en=0.
REQ-021 SHALL discard a pending response on reset mid-operation; a store already clocked into memory stays committed.

Structure
REQ-022 SHALL take from shared package psp_mem_pkg the size enum (SIZE_BYTE/HALF/WORD), the state enum, and MEM_SIZE_DEFAULT=8192.
REQ-023 SHALL place lane-enable, store-shift and load-extract/extend logic in a combinational sub-module mem_lane_align.

Verification
REQ-024 Scenario, byte store: addr 0x0006, size byte, wdata 0x000000AB -> mem_en=4'b0100, mem_wdata[23:16]=0xAB, mem_we=1 for one cycle, resp_valid next cycle with resp_fault=0.
REQ-025 Scenario, signed byte load: word 0x80FF1234 at addr 0x0008, load byte at 0x000B signed -> resp_rdata=0xFFFFFF80 two cycles after accept; unsigned -> 0x00000080.
REQ-026 Scenario, half load: load half at 0x000A unsigned from word 0x80FF1234 -> 0x000080FF; signed -> 0xFFFF80FF.
REQ-027 Scenario, misalignment: word load at 0x0002, then half store at 0x0005 -> each gives resp_fault=1 and resp_rdata=0 after 1 cycle, mem_en=0 and mem_we=0 throughout, memory unchanged.
REQ-028 Scenario, backpressure: resp_ready=0 for 5 cycles -> resp_valid and data held stable, req_ready=0; after resp_ready=1 for one cycle, IDLE and req_ready=1.
REQ-029 Scenario, reset mid-load: rst_n=0 in the READ state -> resp_valid=0 immediately, IDLE after release, no response emitted.
